// File: rtl/wakeup_trig_mc_if.sv
// rtl/wakeup_trig_mc_if.sv - wake-up trigger channel bundle: async lines, service acks, counters and pending status
interface wakeup_trig_mc_if #(
  parameter int NCH = 4,
  parameter int CW  = 20
);
  logic [NCH-1:0]    wake_up;
  logic [NCH-1:0]    wu_serviced;
  logic [NCH*CW-1:0] count;
  logic [NCH-1:0]    wu_valid;
  logic [NCH-1:0]    wu_timeout;
  logic [NCH-1:0]    wu_overrun;
  logic              pend_any;
  logic [3:0]        pend_id;

  modport master (
    output wake_up, wu_serviced,
    input  count, wu_valid, wu_timeout, wu_overrun, pend_any, pend_id
  );

  modport slave (
    input  wake_up, wu_serviced,
    output count, wu_valid, wu_timeout, wu_overrun, pend_any, pend_id
  );
endinterface

// File: rtl/wakeup_trig_mc.sv
// rtl/wakeup_trig_mc.sv - multi-channel wake-up trigger with event counters, timed valid and lowest-index pending encoder
module wakeup_trig_mc #(
  parameter int NCH     = 4,
  parameter int CW      = 20,
  parameter int TW      = 16,
  parameter int TIMEOUT = 30000
) (
  input  logic             clki,
  input  logic             rst,
  wakeup_trig_mc_if.slave  bus
);

  typedef enum logic {
    S_IDLE   = 1'b0,
    S_ACTIVE = 1'b1
  } state_t;

  localparam logic [TW-1:0] TIMER_LAST = TW'(TIMEOUT - 1);

  state_t          state_q [NCH];
  state_t          state_d [NCH];
  logic [2:0]      sync_q  [NCH];
  logic [CW-1:0]   count_q [NCH];
  logic [CW-1:0]   count_d [NCH];
  logic [TW-1:0]   timer_q [NCH];
  logic [TW-1:0]   timer_d [NCH];
  logic [NCH-1:0]  valid_q, valid_d;
  logic [NCH-1:0]  tmo_q, tmo_d;
  logic [NCH-1:0]  ovr_q, ovr_d;
  logic [NCH-1:0]  edge_det;
  logic [3:0]      pend_id_c;

  // Bit 0 is the metastability catcher; edges are taken from the two settled stages.
  always_comb begin
    edge_det = '0;
    for (int i = 0; i < NCH; i++) begin
      edge_det[i] = sync_q[i][1] & ~sync_q[i][2];
    end
  end

  always_ff @(posedge clki or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NCH; i++) begin
        state_q[i] <= S_IDLE;
        sync_q[i]  <= '0;
        count_q[i] <= '0;
        timer_q[i] <= '0;
      end
      valid_q <= '0;
      tmo_q   <= '0;
      ovr_q   <= '0;
    end else begin
      for (int i = 0; i < NCH; i++) begin
        state_q[i] <= state_d[i];
        sync_q[i]  <= {sync_q[i][1:0], bus.wake_up[i]};
        count_q[i] <= count_d[i];
        timer_q[i] <= timer_d[i];
      end
      valid_q <= valid_d;
      tmo_q   <= tmo_d;
      ovr_q   <= ovr_d;
    end
  end

  always_comb begin
    valid_d = valid_q;
    tmo_d   = '0;
    ovr_d   = ovr_q;
    for (int i = 0; i < NCH; i++) begin
      state_d[i] = state_q[i];
      count_d[i] = count_q[i];
      timer_d[i] = timer_q[i];
      case (state_q[i])
        S_IDLE: begin
          if (edge_det[i]) begin
            state_d[i] = S_ACTIVE;
            count_d[i] = count_q[i] + CW'(1);
            timer_d[i] = '0;
            valid_d[i] = 1'b1;
          end
        end
        S_ACTIVE: begin
          // A fresh edge wins over a same-cycle service: the ack is consumed by the retrigger.
          if (edge_det[i]) begin
            count_d[i] = count_q[i] + CW'(1);
            timer_d[i] = '0;
            if (!bus.wu_serviced[i]) begin
              ovr_d[i] = 1'b1;
            end
          end else if (bus.wu_serviced[i]) begin
            state_d[i] = S_IDLE;
            valid_d[i] = 1'b0;
            ovr_d[i]   = 1'b0;
          end else if (timer_q[i] == TIMER_LAST) begin
            state_d[i] = S_IDLE;
            valid_d[i] = 1'b0;
            tmo_d[i]   = 1'b1;
            ovr_d[i]   = 1'b0;
          end else begin
            timer_d[i] = timer_q[i] + TW'(1);
          end
        end
        default: begin
          state_d[i] = S_IDLE;
        end
      endcase
    end
  end

  // Scan downward so the lowest valid index is the last (winning) assignment.
  always_comb begin
    pend_id_c = 4'd0;
    for (int i = NCH - 1; i >= 0; i--) begin
      if (valid_q[i]) begin
        pend_id_c = 4'(i);
      end
    end
  end

  for (genvar g = 0; g < NCH; g++) begin : g_count
    assign bus.count[g*CW +: CW] = count_q[g];
  end

  assign bus.wu_valid   = valid_q;
  assign bus.wu_timeout = tmo_q;
  assign bus.wu_overrun = ovr_q;
  assign bus.pend_any   = |valid_q;
  assign bus.pend_id    = pend_id_c;

endmodule

// File: tb/tb_wakeup_trig_mc.sv
// tb/tb_wakeup_trig_mc.sv - scoreboard bench for wakeup_trig_mc against a time-stamp based reference model
module tb_wakeup_trig_mc;

  localparam int NCH     = 4;
  localparam int CW      = 3;
  localparam int TW      = 8;
  localparam int TIMEOUT = 8;

  typedef struct packed {
    logic [NCH*CW-1:0] count;
    logic [NCH-1:0]    valid;
    logic [NCH-1:0]    tmo;
    logic [NCH-1:0]    ovr;
    logic              pany;
    logic [3:0]        pid;
  } snap_t;

  logic clki = 1'b0;
  logic rst  = 1'b1;

  wakeup_trig_mc_if #(.NCH(NCH), .CW(CW)) bus ();

  wakeup_trig_mc #(.NCH(NCH), .CW(CW), .TW(TW), .TIMEOUT(TIMEOUT)) dut (
    .clki (clki),
    .rst  (rst),
    .bus  (bus)
  );

  always #5 clki = ~clki;

  int    errors = 0;
  int    checks = 0;
  bit    mon_en = 1'b0;
  snap_t exp_q[$];

  // Reference model: per-channel event totals, pending flag and the cycle of the last edge.
  int             m_cnt  [NCH];
  bit             m_val  [NCH];
  bit             m_ovr  [NCH];
  int             m_last [NCH];
  int             m_cyc;
  logic [NCH-1:0] w_hist [3];

  task automatic cmp(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at cycle %0d: got %0h expected %0h", name, m_cyc, act, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < NCH; i++) begin
      m_cnt[i]  = 0;
      m_val[i]  = 0;
      m_ovr[i]  = 0;
      m_last[i] = 0;
    end
    for (int j = 0; j < 3; j++) w_hist[j] = '0;
    exp_q.delete();
  endtask

  // Model one rising clock edge given the inputs presented in the cycle before it.
  task automatic model_edge(input logic [NCH-1:0] w, input logic [NCH-1:0] s);
    snap_t          e;
    logic [NCH-1:0] edges;
    bit             found;
    m_cyc++;
    // An input first seen at edge n registers at edge n+2 if it was low at edge n-1.
    edges     = w_hist[1] & ~w_hist[2];
    w_hist[2] = w_hist[1];
    w_hist[1] = w_hist[0];
    w_hist[0] = w;
    e = '0;
    for (int i = 0; i < NCH; i++) begin
      if (edges[i]) begin
        if (m_val[i] && !s[i]) m_ovr[i] = 1;
        m_val[i]  = 1;
        m_cnt[i]  = (m_cnt[i] + 1) % (1 << CW);
        m_last[i] = m_cyc;
      end else if (m_val[i] && s[i]) begin
        m_val[i] = 0;
        m_ovr[i] = 0;
      end else if (m_val[i] && (m_cyc - m_last[i] == TIMEOUT)) begin
        m_val[i] = 0;
        m_ovr[i] = 0;
        e.tmo[i] = 1'b1;
      end
      e.count[i*CW +: CW] = CW'(m_cnt[i]);
      e.valid[i] = m_val[i];
      e.ovr[i]   = m_ovr[i];
    end
    found = 0;
    for (int i = 0; i < NCH; i++) begin
      if (m_val[i] && !found) begin
        found  = 1;
        e.pid  = 4'(i);
        e.pany = 1'b1;
      end
    end
    exp_q.push_back(e);
  endtask

  task automatic step(input logic [NCH-1:0] w, input logic [NCH-1:0] s);
    @(negedge clki);
    rst             = 1'b0;
    bus.wake_up     = w;
    bus.wu_serviced = s;
    model_edge(w, s);
    mon_en = 1'b1;
  endtask

  task automatic idle(input int n);
    for (int j = 0; j < n; j++) step('0, '0);
  endtask

  task automatic pulse(input logic [NCH-1:0] w);
    step(w, '0);
    step('0, '0);
  endtask

  task automatic do_reset();
    @(negedge clki);
    mon_en          = 1'b0;
    rst             = 1'b1;
    bus.wake_up     = '0;
    bus.wu_serviced = '0;
    #1;
    cmp("rst_count",    64'(bus.count),      64'd0);
    cmp("rst_valid",    64'(bus.wu_valid),   64'd0);
    cmp("rst_timeout",  64'(bus.wu_timeout), 64'd0);
    cmp("rst_overrun",  64'(bus.wu_overrun), 64'd0);
    cmp("rst_pend_any", 64'(bus.pend_any),   64'd0);
    cmp("rst_pend_id",  64'(bus.pend_id),    64'd0);
    model_reset();
    repeat (2) @(posedge clki);
  endtask

  initial begin : monitor
    snap_t e;
    forever begin
      @(posedge clki);
      #1;
      if (mon_en) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL scoreboard_underflow at cycle %0d", m_cyc);
        end else begin
          e = exp_q.pop_front();
          cmp("count",    64'(bus.count),      64'(e.count));
          cmp("valid",    64'(bus.wu_valid),   64'(e.valid));
          cmp("timeout",  64'(bus.wu_timeout), 64'(e.tmo));
          cmp("overrun",  64'(bus.wu_overrun), 64'(e.ovr));
          cmp("pend_any", 64'(bus.pend_any),   64'(e.pany));
          cmp("pend_id",  64'(bus.pend_id),    64'(e.pid));
        end
      end
    end
  end

  initial begin : driver
    logic [NCH-1:0] w, s;
    m_cyc = 0;
    bus.wake_up     = '0;
    bus.wu_serviced = '0;
    model_reset();
    do_reset();

    // Five edges on ch0, then reset while it is pending and retrigger once.
    for (int j = 0; j < 5; j++) pulse(4'b0001);
    idle(2);
    do_reset();
    pulse(4'b0001);
    idle(12);

    // Unserviced single pulse on ch1 runs to timeout.
    pulse(4'b0010);
    idle(14);

    // ch2 serviced a few cycles after it goes valid.
    pulse(4'b0100);
    idle(4);
    step('0, 4'b0100);
    idle(10);

    // Retrigger on ch0 four cycles apart without service.
    pulse(4'b0001);
    idle(2);
    pulse(4'b0001);
    idle(14);

    // Simultaneous edges on ch3 and ch1, then service in index order.
    pulse(4'b1010);
    idle(2);
    step('0, 4'b0010);
    idle(1);
    step('0, 4'b1000);
    idle(10);

    // Counter wrap on ch0, then edge coinciding with service.
    for (int j = 0; j < 8; j++) pulse(4'b0001);
    step(4'b0001, '0);
    step('0, '0);
    step('0, 4'b0001);
    idle(12);

    // Dense then sparse random traffic, with a reset in between.
    for (int j = 0; j < 1500; j++) begin
      for (int i = 0; i < NCH; i++) begin
        w[i] = ($urandom_range(0, 2) == 0);
        s[i] = ($urandom_range(0, 5) == 0);
      end
      step(w, s);
    end
    do_reset();
    for (int j = 0; j < 1500; j++) begin
      for (int i = 0; i < NCH; i++) begin
        w[i] = ($urandom_range(0, 11) == 0);
        s[i] = ($urandom_range(0, 15) == 0);
      end
      step(w, s);
    end
    idle(4);

    @(posedge clki);
    #2;
    cmp("scoreboard_drained", 64'(exp_q.size()), 64'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
